// File: rtl/maze_frame_ctrl_if.sv
// Request/ack and renderer-facing signals of the maze frame controller.
// slave = controller side, master = loader/game/VGA side.
interface maze_frame_ctrl_if #(
   parameter int DIM_MAX = 3
);
   localparam int PW = DIM_MAX * DIM_MAX;
   localparam int DW = $clog2(DIM_MAX) + 1;
   localparam int CW = $clog2(DIM_MAX);

   logic          vblank;
   logic          load_req;
   logic [PW-1:0] load_path;
   logic [DW-1:0] load_w;
   logic [DW-1:0] load_h;
   logic          load_ack;
   logic          cell_req;
   logic [CW-1:0] cell_x;
   logic [CW-1:0] cell_y;
   logic          cell_val;
   logic          cell_ack;
   logic          req_err;
   logic [PW-1:0] path_data;
   logic [DW-1:0] maze_width;
   logic [DW-1:0] maze_height;
   logic          dirty;
   logic          commit;

   modport slave (
      input  vblank, load_req, load_path, load_w, load_h,
             cell_req, cell_x, cell_y, cell_val,
      output load_ack, cell_ack, req_err, path_data, maze_width,
             maze_height, dirty, commit
   );

   modport master (
      output vblank, load_req, load_path, load_w, load_h,
             cell_req, cell_x, cell_y, cell_val,
      input  load_ack, cell_ack, req_err, path_data, maze_width,
             maze_height, dirty, commit
   );
endinterface

// File: rtl/maze_frame_ctrl.sv
// Maze picture owner: arbitrates loader/cell writes into a shadow, commits shadow to live at vblank rise.
// Latency: request accepted and ack raised at the sampling edge; live updates at the next vblank rising edge.
// Backpressure: 4-phase req/ack, one request in flight; FRAME_CNT_EN adds a 16-bit vblank counter.
module maze_frame_ctrl #(
   parameter int DIM_MAX   = 3,
   parameter int RESET_DIM = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   maze_frame_ctrl_if.slave     bus
`ifdef FRAME_CNT_EN
   ,
   output logic [15:0]          frame_cnt
`endif
);
   localparam int PW = DIM_MAX * DIM_MAX;
   localparam int DW = $clog2(DIM_MAX) + 1;
   localparam int IW = $clog2(PW);
   localparam logic [DW-1:0] DMAX = DW'(DIM_MAX);
   localparam logic [DW-1:0] RDIM = DW'(RESET_DIM);

   typedef enum logic [1:0] {IDLE, ACK_LOAD, ACK_CELL} state_t;

   state_t        state, state_nxt;
   logic          rr_cell;
   logic [PW-1:0] sh_path;
   logic [DW-1:0] sh_w, sh_h;
   logic          vblank_d;
   logic          grant_load, grant_cell;
   logic          load_ok, cell_ok, vblank_rise;
   logic [IW-1:0] cell_idx;

   always_comb begin
      state_nxt  = state;
      grant_load = 1'b0;
      grant_cell = 1'b0;
      case (state)
         IDLE: begin
            // on a tie, grant whoever was not granted last
            if (bus.load_req && (!bus.cell_req || !rr_cell)) begin
               grant_load = 1'b1;
               state_nxt  = ACK_LOAD;
            end else if (bus.cell_req) begin
               grant_cell = 1'b1;
               state_nxt  = ACK_CELL;
            end
         end
         ACK_LOAD: if (!bus.load_req) state_nxt = IDLE;
         ACK_CELL: if (!bus.cell_req) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign load_ok = (bus.load_w != '0) && (bus.load_w <= DMAX) &&
                    (bus.load_h != '0) && (bus.load_h <= DMAX);
   assign cell_ok = (DW'(bus.cell_x) < sh_w) && (DW'(bus.cell_y) < sh_h);
   assign cell_idx = IW'(bus.cell_x) * IW'(DIM_MAX) + IW'(bus.cell_y);
   assign vblank_rise = bus.vblank && !vblank_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         rr_cell         <= 1'b0;
         sh_path         <= '0;
         sh_w            <= RDIM;
         sh_h            <= RDIM;
         vblank_d        <= 1'b0;
         bus.load_ack    <= 1'b0;
         bus.cell_ack    <= 1'b0;
         bus.req_err     <= 1'b0;
         bus.path_data   <= '0;
         bus.maze_width  <= RDIM;
         bus.maze_height <= RDIM;
         bus.dirty       <= 1'b0;
         bus.commit      <= 1'b0;
      end else begin
         state        <= state_nxt;
         vblank_d     <= bus.vblank;
         bus.load_ack <= (state_nxt == ACK_LOAD);
         bus.cell_ack <= (state_nxt == ACK_CELL);
         bus.req_err  <= (grant_load && !load_ok) || (grant_cell && !cell_ok);
         if (grant_load || grant_cell)
            rr_cell <= grant_load;
         if (grant_load && load_ok) begin
            sh_path <= bus.load_path;
            sh_w    <= bus.load_w;
            sh_h    <= bus.load_h;
         end
         if (grant_cell && cell_ok)
            sh_path[cell_idx] <= bus.cell_val;
         // live takes the pre-update shadow if an acceptance coincides
         bus.commit <= vblank_rise && bus.dirty;
         if (vblank_rise && bus.dirty) begin
            bus.path_data   <= sh_path;
            bus.maze_width  <= sh_w;
            bus.maze_height <= sh_h;
         end
         if ((grant_load && load_ok) || (grant_cell && cell_ok))
            bus.dirty <= 1'b1;
         else if (vblank_rise)
            bus.dirty <= 1'b0;
      end
   end

`ifdef FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         frame_cnt <= '0;
      else if (vblank_rise)
         frame_cnt <= frame_cnt + 16'd1;
   end
`endif
endmodule
